// File: rtl/tour_cmd_seq_pkg.sv
// Shared constants for the knight's-tour command sequencer: board size, move
// encodings, motion opcodes/headings and the sequencer state type.
package tour_cmd_seq_pkg;

  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;
  localparam int MV_W      = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  localparam logic [3:0] OP_MOVE     = 4'h2;
  localparam logic [3:0] OP_MOVE_FAN = 4'h3;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;
  localparam logic [7:0] HEAD_W = 8'h3F;

  // Move names read as horizontal then vertical step, e.g. R1U2 = (+1,+2).
  localparam logic [MV_W-1:0] MV_R1U2 = 8'h01;
  localparam logic [MV_W-1:0] MV_L1U2 = 8'h02;
  localparam logic [MV_W-1:0] MV_L2U1 = 8'h04;
  localparam logic [MV_W-1:0] MV_L2D1 = 8'h08;
  localparam logic [MV_W-1:0] MV_L1D2 = 8'h10;
  localparam logic [MV_W-1:0] MV_R1D2 = 8'h20;
  localparam logic [MV_W-1:0] MV_R2D1 = 8'h40;
  localparam logic [MV_W-1:0] MV_R2U1 = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_V_ISS,
    ST_V_WT,
    ST_H_ISS,
    ST_H_WT
  } state_t;

  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] head,
                                         input logic [3:0] sq);
    return {op, head, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Bundle of solver-read and motion-command handshake signals between the
// sequencer (slave) and its environment (master).
interface tour_cmd_seq_if;
  import tour_cmd_seq_pkg::*;

  logic             tour_go;
  logic [MV_W-1:0]  move;
  logic [IDX_W-1:0] mv_indx;
  logic [15:0]      cmd;
  logic             cmd_vld;
  logic             cmd_rdy;
  logic             cmd_cmplt;
  logic             busy;
  logic             tour_done;
  logic             err;

  modport master (
    output tour_go, move, cmd_rdy, cmd_cmplt,
    input  mv_indx, cmd, cmd_vld, busy, tour_done, err
  );

  modport slave (
    input  tour_go, move, cmd_rdy, cmd_cmplt,
    output mv_indx, cmd, cmd_vld, busy, tour_done, err
  );

endinterface

// File: rtl/tour_cmd_seq_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg
// (heading + square count each) and flags words that are not exactly one-hot.
module tour_cmd_seq_move_decode
  import tour_cmd_seq_pkg::*;
(
  input  logic [MV_W-1:0] i_mv,
  output logic [7:0]      o_v_head,
  output logic [3:0]      o_v_sq,
  output logic [7:0]      o_h_head,
  output logic [3:0]      o_h_sq,
  output logic            o_legal
);

  always_comb begin
    o_v_head = HEAD_N;
    o_v_sq   = 4'd0;
    o_h_head = HEAD_E;
    o_h_sq   = 4'd0;
    o_legal  = $onehot(i_mv);
    case (i_mv)
      MV_R1U2: begin o_v_head = HEAD_N; o_v_sq = 4'd2; o_h_head = HEAD_E; o_h_sq = 4'd1; end
      MV_L1U2: begin o_v_head = HEAD_N; o_v_sq = 4'd2; o_h_head = HEAD_W; o_h_sq = 4'd1; end
      MV_L2U1: begin o_v_head = HEAD_N; o_v_sq = 4'd1; o_h_head = HEAD_W; o_h_sq = 4'd2; end
      MV_L2D1: begin o_v_head = HEAD_S; o_v_sq = 4'd1; o_h_head = HEAD_W; o_h_sq = 4'd2; end
      MV_L1D2: begin o_v_head = HEAD_S; o_v_sq = 4'd2; o_h_head = HEAD_W; o_h_sq = 4'd1; end
      MV_R1D2: begin o_v_head = HEAD_S; o_v_sq = 4'd2; o_h_head = HEAD_E; o_h_sq = 4'd1; end
      MV_R2D1: begin o_v_head = HEAD_S; o_v_sq = 4'd1; o_h_head = HEAD_E; o_h_sq = 4'd2; end
      MV_R2U1: begin o_v_head = HEAD_N; o_v_sq = 4'd1; o_h_head = HEAD_E; o_h_sq = 4'd2; end
      default: begin end
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Walks the solver's stored tour and issues a vertical then a horizontal motion
// command per move over valid/ready, waiting for each command to complete.
module tour_cmd_seq
  import tour_cmd_seq_pkg::*;
(
  input logic           clk,
  input logic           rst,
  tour_cmd_seq_if.slave bus
);

  state_t           r_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic [MV_W-1:0]  r_mv_q;
  logic [15:0]      r_cmd;
  logic             r_cmd_vld;
  logic             r_busy;
  logic             r_tour_done;
  logic             r_err;

  logic [7:0] w_v_head;
  logic [3:0] w_v_sq;
  logic [7:0] w_h_head;
  logic [3:0] w_h_sq;
  logic       w_legal;

  tour_cmd_seq_move_decode u_decode (
    .i_mv     (r_mv_q),
    .o_v_head (w_v_head),
    .o_v_sq   (w_v_sq),
    .o_h_head (w_h_head),
    .o_h_sq   (w_h_sq),
    .o_legal  (w_legal)
  );

  // FETCH gives the solver one cycle of read latency; DECODE then judges the latched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mv_indx   <= '0;
      r_mv_q      <= '0;
      r_cmd       <= 16'h0000;
      r_cmd_vld   <= 1'b0;
      r_busy      <= 1'b0;
      r_tour_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tour_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.tour_go) begin
            r_mv_indx <= '0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_mv_q  <= bus.move;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (w_legal) begin
            r_cmd     <= mk_cmd(OP_MOVE, w_v_head, w_v_sq);
            r_cmd_vld <= 1'b1;
            r_state   <= ST_V_ISS;
          end else begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_V_ISS: begin
          if (bus.cmd_rdy) begin
            r_cmd_vld <= 1'b0;
            r_state   <= ST_V_WT;
          end
        end
        ST_V_WT: begin
          if (bus.cmd_cmplt) begin
            r_cmd     <= mk_cmd(OP_MOVE_FAN, w_h_head, w_h_sq);
            r_cmd_vld <= 1'b1;
            r_state   <= ST_H_ISS;
          end
        end
        ST_H_ISS: begin
          if (bus.cmd_rdy) begin
            r_cmd_vld <= 1'b0;
            r_state   <= ST_H_WT;
          end
        end
        ST_H_WT: begin
          if (bus.cmd_cmplt) begin
            if (r_mv_indx == LAST_IDX) begin
              r_tour_done <= 1'b1;
              r_busy      <= 1'b0;
              r_mv_indx   <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + 1'b1;
              r_state   <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mv_indx   = r_mv_indx;
  assign bus.cmd       = r_cmd;
  assign bus.cmd_vld   = r_cmd_vld;
  assign bus.busy      = r_busy;
  assign bus.tour_done = r_tour_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: random tours checked against a displacement-table
// model of the expected command stream, plus directed corner cases.
module tb_tour_cmd_seq;

  localparam int TB_MOVES = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tour_cmd_seq_if bus ();

  tour_cmd_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] moveTable [32];
  int dxTab [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dyTab [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  logic [15:0] gotQ [$];
  logic [15:0] expQ [$];
  int doneCount;
  bit errSeen;

  // Solver model: answers the presented index half a cycle later.
  always @(negedge clk) bus.move = moveTable[bus.mv_indx];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] refCmd(input logic [7:0] mv, input bit horiz);
    int k;
    int d;
    k = 0;
    for (int i = 0; i < 8; i++) if (mv[i]) k = i;
    if (!horiz) begin
      d = dyTab[k];
      return {4'h2, (d > 0) ? 8'h00 : 8'h7F, 4'((d > 0) ? d : -d)};
    end
    d = dxTab[k];
    return {4'h3, (d > 0) ? 8'hBF : 8'h3F, 4'((d > 0) ? d : -d)};
  endfunction

  function automatic logic [7:0] randomMove();
    logic [7:0] one;
    one = 8'h01;
    return one << $urandom_range(7, 0);
  endfunction

  task automatic buildExpected(input int lastIdx);
    expQ.delete();
    for (int i = 0; i <= lastIdx; i++) begin
      expQ.push_back(refCmd(moveTable[i], 1'b0));
      expQ.push_back(refCmd(moveTable[i], 1'b1));
    end
  endtask

  task automatic compareCmds(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput($sformatf("%s_cmd%0d", tag, i), gotQ[i], expQ[i]);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_indx"}, bus.mv_indx, 0);
    checkOutput({tag, "_cmd"},  bus.cmd, 16'h0000);
    checkOutput({tag, "_vld"},  bus.cmd_vld, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.tour_done, 0);
    checkOutput({tag, "_err"},  bus.err, 0);
  endtask

  // Pulses tour_go and checks the first vertical command appears two clocks later.
  task automatic startTour(input string tag);
    bus.tour_go = 1'b1;
    bus.cmd_rdy = 1'b1;
    bus.cmd_cmplt = 1'b0;
    tick();
    bus.tour_go = 1'b0;
    checkOutput({tag, "_go_busy"}, bus.busy, 1);
    checkOutput({tag, "_go_indx"}, bus.mv_indx, 0);
    checkOutput({tag, "_go_err"},  bus.err, 0);
    checkOutput({tag, "_go_vld"},  bus.cmd_vld, 0);
    tick();
    checkOutput({tag, "_fetch_vld"}, bus.cmd_vld, 0);
    tick();
    checkOutput({tag, "_issue_vld"}, bus.cmd_vld, 1);
    checkOutput({tag, "_issue_cmd"}, bus.cmd, refCmd(moveTable[0], 1'b0));
  endtask

  // Services the command port until tour_done, err, a halt point or timeout.
  task automatic applyStimulus(input string tag, input int maxCycles, input int stallCycles,
                               input bit spurious, input int haltIdx);
    int cycles;
    int cd;
    int stall;
    bit stalling;
    bit halt;
    bit finished;
    logic [15:0] heldCmd;
    cycles = 0; cd = -1; stall = stallCycles; stalling = 0; halt = 0; finished = 0;
    heldCmd = '0;
    gotQ.delete();
    doneCount = 0;
    errSeen = 0;
    while (!finished && cycles < maxCycles) begin
      cycles++;
      bus.cmd_cmplt = 1'b0;
      bus.tour_go = 1'b0;
      if (cd > 0) begin
        cd--;
        bus.cmd_cmplt = (cd == 0);
      end
      if (bus.tour_done) doneCount++;
      if (bus.err) begin
        errSeen = 1;
        finished = 1;
      end else if (bus.tour_done) begin
        finished = 1;
      end else begin
        bus.cmd_rdy = 1'b1;
        if (stall > 0 && (bus.cmd_vld || stalling)) begin
          if (!stalling) begin
            stalling = 1;
            heldCmd = bus.cmd;
          end else begin
            checkOutput({tag, "_bp_vld_held"}, bus.cmd_vld, 1);
            checkOutput({tag, "_bp_cmd_stable"}, bus.cmd, heldCmd);
          end
          bus.cmd_rdy = 1'b0;
          stall--;
          if (spurious && stall == 5) begin
            bus.cmd_cmplt = 1'b1;
            bus.tour_go = 1'b1;
          end
        end
        if (bus.cmd_vld && bus.cmd_rdy) begin
          gotQ.push_back(bus.cmd);
          cd = 3;
          if (bus.cmd[15:12] == 4'h3 && int'(bus.mv_indx) == haltIdx) halt = 1;
        end
        tick();
        if (halt) finished = 1;
      end
    end
    bus.cmd_cmplt = 1'b0;
    bus.tour_go = 1'b0;
    checkOutput({tag, "_no_timeout"}, finished, 1);
  endtask

  initial begin
    bus.tour_go = 1'b0;
    bus.cmd_rdy = 1'b0;
    bus.cmd_cmplt = 1'b0;
    for (int i = 0; i < 32; i++) moveTable[i] = 8'h01;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    rst = 1'b0;
    tick();

    // Full tour with two directed leading moves.
    for (int i = 0; i < TB_MOVES; i++) moveTable[i] = randomMove();
    moveTable[0] = 8'h01;
    moveTable[1] = 8'h08;
    startTour("t1");
    applyStimulus("t1", 2000, 0, 0, -1);
    buildExpected(TB_MOVES - 1);
    compareCmds("t1");
    if (gotQ.size() >= 4) begin
      checkOutput("dir_v01", gotQ[0], 16'h2002);
      checkOutput("dir_h01", gotQ[1], 16'h3BF1);
      checkOutput("dir_v08", gotQ[2], 16'h27F1);
      checkOutput("dir_h08", gotQ[3], 16'h33F2);
    end
    checkOutput("t1_done_count", doneCount, 1);
    tick();
    checkOutput("t1_done_pulse", bus.tour_done, 0);
    checkOutput("t1_busy_after", bus.busy, 0);
    checkOutput("t1_indx_after", bus.mv_indx, 0);

    // Backpressure on the first leg with a stray complete and a stray start.
    for (int i = 0; i < TB_MOVES; i++) moveTable[i] = randomMove();
    startTour("t2");
    applyStimulus("t2", 2000, 10, 1, -1);
    buildExpected(TB_MOVES - 1);
    compareCmds("t2");
    checkOutput("t2_done_count", doneCount, 1);
    tick();

    // Illegal move word part way through the tour.
    for (int i = 0; i < TB_MOVES; i++) moveTable[i] = randomMove();
    moveTable[5] = 8'h03;
    startTour("t3");
    applyStimulus("t3", 2000, 0, 0, -1);
    buildExpected(4);
    compareCmds("t3");
    checkOutput("t3_err_seen", errSeen, 1);
    checkOutput("t3_busy_low", bus.busy, 0);
    repeat (3) tick();
    checkOutput("t3_err_sticky", bus.err, 1);
    checkOutput("t3_no_vld", bus.cmd_vld, 0);
    moveTable[5] = randomMove();
    startTour("t4");
    applyStimulus("t4", 2000, 0, 0, -1);
    buildExpected(TB_MOVES - 1);
    compareCmds("t4");
    checkOutput("t4_done_count", doneCount, 1);
    tick();

    // Reset while waiting on the horizontal leg of index 12, with tour_go alongside.
    for (int i = 0; i < TB_MOVES; i++) moveTable[i] = randomMove();
    startTour("t5");
    applyStimulus("t5", 2000, 0, 0, 12);
    buildExpected(12);
    compareCmds("t5");
    rst = 1'b1;
    bus.tour_go = 1'b1;
    tick();
    checkReset("midrst");
    rst = 1'b0;
    bus.tour_go = 1'b0;
    tick();
    checkOutput("midrst_idle_busy", bus.busy, 0);
    for (int i = 0; i < TB_MOVES; i++) moveTable[i] = randomMove();
    startTour("t6");
    applyStimulus("t6", 2000, 0, 0, -1);
    buildExpected(TB_MOVES - 1);
    compareCmds("t6");
    checkOutput("t6_done_count", doneCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
